// File: rtl/fuzzy_pkg_2.sv
// rtl/fuzzy_pkg_2.sv - shared labels, center mapping and state encoding for the phase-2 defuzzifier
package fuzzy_pkg_2;

    localparam logic [4:0] NBB = 5'd0;
    localparam logic [4:0] NB7 = 5'd1;
    localparam logic [4:0] NB6 = 5'd2;
    localparam logic [4:0] NB5 = 5'd3;
    localparam logic [4:0] NB4 = 5'd4;
    localparam logic [4:0] NB3 = 5'd5;
    localparam logic [4:0] NB2 = 5'd6;
    localparam logic [4:0] NB1 = 5'd7;
    localparam logic [4:0] ZE  = 5'd8;
    localparam logic [4:0] PB1 = 5'd9;
    localparam logic [4:0] PB2 = 5'd10;
    localparam logic [4:0] PB3 = 5'd11;
    localparam logic [4:0] PB4 = 5'd12;
    localparam logic [4:0] PB5 = 5'd13;
    localparam logic [4:0] PB6 = 5'd14;
    localparam logic [4:0] PB7 = 5'd15;
    localparam logic [4:0] PBB = 5'd16;

    localparam logic [4:0] LBL_ZE  = ZE;
    localparam logic [4:0] LBL_MAX = PBB;

    typedef enum logic [1:0] {
        ST_ACC,
        ST_DIV,
        ST_OUT
    } state_t;

    // Labels are symmetric around ZE, so the center is a signed offset from it.
    function automatic int center_of(input logic [4:0] lbl, input int step);
        return (int'(lbl) - int'(LBL_ZE)) * step;
    endfunction

endpackage

// File: rtl/seq_div_u.sv
// rtl/seq_div_u.sv - unsigned restoring divider, one quotient bit per clock
module seq_div_u #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);
    localparam int CW = $clog2(W + 1);

    logic [W:0]    rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [W:0]    trial;

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        trial  = {rem_q[W-1:0], quo_q[W-1]};
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = CW'(W);
            done_d = 1'b0;
        end else if (cnt_q != '0) begin
            // Dividend bits shift out of the top of quo while quotient bits shift in at the bottom.
            if (trial >= {1'b0, dvs_q}) begin
                rem_d = trial - {1'b0, dvs_q};
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = trial;
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/fuzzy_defuzz_2.sv
// rtl/fuzzy_defuzz_2.sv - weighted-centroid defuzzifier producing a signed crisp correction
module fuzzy_defuzz_2
    import fuzzy_pkg_2::*;
#(
    parameter int W_W         = 8,
    parameter int CENTER_STEP = 16,
    parameter int MAX_TERMS   = 17,
    parameter int ACC_W       = 24,
    parameter int OUT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              in_label,
    input  logic [W_W-1:0]          in_weight,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] df_out,
    output logic                    err
);
    localparam int CNT_W = $clog2(MAX_TERMS + 1);
    localparam logic [ACC_W-1:0] POS_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic [ACC_W-1:0] NEG_MAG = ACC_W'(1 << (OUT_W - 1));

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] num_q, num_d;
    logic [ACC_W-1:0]        den_q, den_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [OUT_W-1:0] df_q, df_d;
    logic                    err_q, err_d;
    logic                    start_q, start_d;
    logic                    neg_q, neg_d;
    logic [ACC_W-1:0]        abs_num;
    logic [ACC_W-1:0]        quo;
    logic                    div_done;
    int                      prod;

    assign abs_num = num_q[ACC_W-1] ? ACC_W'(-num_q) : ACC_W'(num_q);

    seq_div_u #(.W(ACC_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (start_q),
        .dividend (abs_num),
        .divisor  (den_q),
        .quotient (quo),
        .done     (div_done)
    );

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        den_d   = den_q;
        cnt_d   = cnt_q;
        df_d    = df_q;
        err_d   = err_q;
        start_d = 1'b0;
        neg_d   = neg_q;
        prod    = int'(in_weight) * center_of(in_label, CENTER_STEP);
        case (state_q)
            ST_ACC: begin
                if (in_valid) begin
                    if (in_label > LBL_MAX || cnt_q == CNT_W'(MAX_TERMS)) begin
                        err_d = 1'b1;
                    end else begin
                        num_d = num_q + ACC_W'(prod);
                        den_d = den_q + ACC_W'(in_weight);
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        if (den_d == '0) begin
                            df_d    = '0;
                            state_d = ST_OUT;
                        end else begin
                            start_d = 1'b1;
                            state_d = ST_DIV;
                        end
                    end
                end
            end
            ST_DIV: begin
                // The first DIV cycle only loads the divider; done is stale until that load lands.
                if (start_q) begin
                    neg_d = num_q[ACC_W-1];
                end else if (div_done) begin
                    if (neg_q) begin
                        df_d = (quo >= NEG_MAG) ? {1'b1, {(OUT_W-1){1'b0}}}
                                                : -$signed(OUT_W'(quo));
                    end else begin
                        df_d = (quo > POS_MAX) ? {1'b0, {(OUT_W-1){1'b1}}}
                                               : $signed(OUT_W'(quo));
                    end
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    num_d   = '0;
                    den_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
            num_q   <= '0;
            den_q   <= '0;
            cnt_q   <= '0;
            df_q    <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            den_q   <= den_d;
            cnt_q   <= cnt_d;
            df_q    <= df_d;
            err_q   <= err_d;
            start_q <= start_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign df_out    = df_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fuzzy_defuzz_2.sv
// tb/tb_fuzzy_defuzz_2.sv - directed self-checking bench for fuzzy_defuzz_2
module tb_fuzzy_defuzz_2;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [4:0]         in_label = '0;
    logic [7:0]         in_weight = '0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] df_out;
    logic               err;

    int checks = 0;
    int errors = 0;

    fuzzy_defuzz_2 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_label  (in_label),
        .in_weight (in_weight),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .df_out    (df_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input int lbl, input int w, input bit last);
        @(negedge clk);
        in_valid  = 1'b1;
        in_label  = lbl[4:0];
        in_weight = w[7:0];
        in_last   = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, int'(in_ready), 1);
        chk({tag, "_out_valid_after"}, int'(out_valid), 0);
    endtask

    task automatic finish_set(input string tag, input int exp_lat, input int exp_df, input int exp_err);
        int e;
        wait_out(e);
        chk({tag, "_latency"}, e, exp_lat);
        chk({tag, "_df"}, int'(df_out), exp_df);
        chk({tag, "_err"}, int'(err), exp_err);
        chk({tag, "_in_ready_out"}, int'(in_ready), 0);
        take(tag);
    endtask

    initial begin
        int e;
        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_err", int'(err), 0);
        chk("rst_df", int'(df_out), 0);
        @(negedge clk);
        rst = 1'b0;

        beat(12, 255, 1'b1);
        finish_set("single_pb4", 26, 64, 0);

        beat(4, 100, 1'b0);
        beat(12, 100, 1'b1);
        finish_set("balanced", 26, 0, 0);

        beat(16, 200, 1'b0);
        beat(10, 100, 1'b1);
        finish_set("pos96", 26, 96, 0);

        beat(0, 50, 1'b0);
        beat(9, 50, 1'b1);
        finish_set("neg56", 26, -56, 0);

        beat(0, 1, 1'b0);
        beat(8, 2, 1'b1);
        finish_set("trunc42", 26, -42, 0);

        beat(3, 0, 1'b1);
        finish_set("zero_den", 0, 0, 0);

        beat(20, 90, 1'b1);
        finish_set("bad_label", 0, 0, 1);

        beat(12, 255, 1'b1);
        wait_out(e);
        chk("bp_latency", e, 26);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_df", int'(df_out), 64);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        chk("bp_err_sticky", int'(err), 1);
        take("bp");

        beat(16, 100, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_err", int'(err), 0);
        chk("mid_rst_df", int'(df_out), 0);
        @(negedge clk);
        rst = 1'b0;
        beat(4, 10, 1'b1);
        finish_set("post_rst", 26, -64, 0);

        for (int i = 0; i < 17; i++) begin
            beat(9, 1, 1'b0);
        end
        beat(16, 255, 1'b1);
        finish_set("term_overflow", 26, 16, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
